uart_tx_frame: RTL and testbench
================================

UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, setting clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit between data and stop.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit (sum latch result, zero-extended upstream).
REQ-006 The block SHALL have port uart_tx_en  input  1  asynchronous level from pad; a rising edge requests one frame.
REQ-007 The block SHALL have port uartbusy  output  1  high while a frame is in progress.
REQ-008 The block SHALL have port uart_txd  output  1  serial line, idle high.
REQ-009 The block SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 uart_tx_en SHALL pass through a 2-flop synchronizer plus a third history flop; rising edge = sync2 high and history low.
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is unreachable when PARITY_EN=0.
REQ-012 In IDLE, a detected rising edge SHALL capture tx_data into a shift register, compute even parity (XOR of the 8 bits), clear the bit counter, and enter START.
REQ-013 Latency: if uart_tx_en is first sampled high at edge k, uart_txd SHALL be 0 and uartbusy 1 after edge k+2.
REQ-014 START SHALL drive uart_txd=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL drive the 8 captured bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7, go to PARITY if PARITY_EN=1, else STOP.
REQ-016 PARITY SHALL drive the captured even-parity bit for CLKS_PER_BIT cycles, then enter STOP.
REQ-017 STOP SHALL drive uart_txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 uart_txd SHALL be registered and SHALL be 1 in IDLE.
REQ-019 uartbusy SHALL be registered, high in every state except IDLE; it is high for exactly (10+PARITY_EN)*CLKS_PER_BIT consecutive cycles per frame.
REQ-020 tx_done SHALL be high for exactly one cycle: the cycle in which uartbusy first reads 0 after a frame.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 on each bit boundary, and be held at 0 in IDLE.
REQ-022 Rising edges detected while not in IDLE SHALL be dropped, not queued; the history flop keeps tracking, so a level held high produces no further frame.
REQ-023 Changes on tx_data after capture SHALL NOT affect the frame in progress.
REQ-024 A rising edge detected in the same cycle that STOP transitions to IDLE SHALL be dropped. A new frame starts only from an edge detected while already in IDLE.
REQ-025 Back-to-back frames SHALL be separated by at least one IDLE cycle with uart_txd=1.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL set state=IDLE, uart_txd=1, uartbusy=0, tx_done=0, and clear the baud counter, bit index, shift register, parity bit and all three synchronizer/history flops.
REQ-027 Reset asserted mid-frame SHALL abort the frame with the above values after the same edge; no tx_done is produced.
REQ-028 Because the sync flops reset to 0, a uart_tx_en held high across reset release SHALL be seen as one rising edge and SHALL start one frame.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Basic frame: tx_data=8'h0B, uart_tx_en 0->1 at edge k. Required: uart_txd=0 at k+2..k+5, then 1,1,0,1,0,0,0,0 (4 cycles each), then stop 1 for 4 cycles. uartbusy high for 40 cycles. tx_done pulses once on the first cycle uartbusy is low.
REQ-030 Parity: PARITY_EN=1, tx_data=8'h07. Required: parity bit 1 appears after bit 7 for 4 cycles; uartbusy high 44 cycles. With tx_data=8'h03 the parity bit is 0.
REQ-031 Dropped request: uart_tx_en is pulsed low then high again mid-DATA while tx_data changes to 8'hFF. Required: the frame still carries 8'h0B and no second frame follows. uart_tx_en held high after the frame produces no frame.
REQ-032 Reset mid-frame: reset=1 for one cycle during DATA bit 3. Required: uart_txd=1 and uartbusy=0 on the next cycle, tx_done stays 0, and a fresh rising edge later gives a complete correct frame.
REQ-033 Held-through-reset: uart_tx_en=1 before and after reset release. Required: exactly one frame starting 3 edges after release.
REQ-034 Baud sweep: CLKS_PER_BIT=2 and 104 with tx_data=8'hA5. Required: every bit period is exactly CLKS_PER_BIT cycles and the decoded byte is 8'hA5.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Serialises one byte as an 8N1 (or 8E1) UART frame each time a rising edge
//   is seen on an asynchronous request level.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   PARITY_EN    : 1 inserts an even-parity bit between data and stop
//
// Ports
//   clk        : system clock, all state on its rising edge
//   reset      : synchronous active-high reset
//   tx_data    : byte to send, captured when a request is accepted
//   uart_tx_en : asynchronous request level; a rising edge requests a frame
//   uartbusy   : high for the whole frame (registered)
//   uart_txd   : serial line, idle high (registered)
//   tx_done    : one-cycle pulse in the first cycle uartbusy is low again
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       uart_tx_en,
  output logic       uartbusy,
  output logic       uart_txd,
  output logic       tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sync1_q, sync2_q, hist_q;
  logic                en_rise;
  logic                bit_end;

  // Two synchroniser stages plus a history flop. The history flop tracks the
  // synchronised level in every state, so a request held high while busy is
  // simply absorbed and never turns into a later frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= uart_tx_en;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign en_rise = sync2_q & ~hist_q;
  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    txd_d     = 1'b1;

    // Baud counter free-runs through every non-idle state and wraps on each
    // bit boundary; IDLE pins it to zero so a new frame starts aligned.
    if (state_q == IDLE) begin
      baud_d = '0;
    end else if (bit_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        // Only IDLE consumes a request; edges seen anywhere else are dropped.
        if (en_rise) begin
          shift_d   = tx_data;
          parity_d  = ^tx_data;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line and busy are registered from the next state so they change on the
    // same edge as the state itself.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign uart_txd = txd_q;
  assign uartbusy = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Four instances cover CLKS_PER_BIT=4 (no parity), 4 (even parity), 2 and
//   104. Frames are recorded one sample per cycle on the falling edge and
//   decoded afterwards against hand-computed expectations.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0][7:0] data_r;
  logic [3:0]      en_r;
  logic [3:0]      busy_w;
  logic [3:0]      txd_w;
  logic [3:0]      done_w;

  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_data(data_r[0]), .uart_tx_en(en_r[0]),
    .uartbusy(busy_w[0]), .uart_txd(txd_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(data_r[1]), .uart_tx_en(en_r[1]),
    .uartbusy(busy_w[1]), .uart_txd(txd_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(data_r[2]), .uart_tx_en(en_r[2]),
    .uartbusy(busy_w[2]), .uart_txd(txd_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.CLKS_PER_BIT(104), .PARITY_EN(0)) u_dut3 (
    .clk(clk), .reset(reset), .tx_data(data_r[3]), .uart_tx_en(en_r[3]),
    .uartbusy(busy_w[3]), .uart_txd(txd_w[3]), .tx_done(done_w[3]));

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int cpb_of(input int d);
    case (d)
      2:       return 2;
      3:       return 104;
      default: return 4;
    endcase
  endfunction

  function automatic int par_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  // Per-cycle samples of the selected instance; index = edges since start - 1.
  logic txd_s[$];
  logic busy_s[$];
  logic done_s[$];

  task automatic capture(input int idx, input int cycles, input bit clear);
    if (clear) begin
      txd_s.delete();
      busy_s.delete();
      done_s.delete();
    end
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      txd_s.push_back(txd_w[idx]);
      busy_s.push_back(busy_w[idx]);
      done_s.push_back(done_w[idx]);
    end
  endtask

  int         a_first, a_len, a_frames, a_done;
  bit         a_done_ok, a_periods_ok;
  logic       a_start, a_par, a_stop;
  logic [7:0] a_byte;

  task automatic analyze(input int cpb, input int par);
    logic prev;
    int   nb;
    int   base;
    a_first = -1; a_len = 0; a_frames = 0; a_done = 0;
    a_done_ok = 1'b0; a_periods_ok = 1'b1;
    a_start = 1'b1; a_par = 1'b0; a_stop = 1'b0; a_byte = 8'h00;
    prev = 1'b0;
    for (int i = 0; i < busy_s.size(); i++) begin
      if (busy_s[i] && !prev) begin
        a_frames++;
        if (a_first < 0) a_first = i + 1;
      end
      if (busy_s[i]) a_len++;
      if (done_s[i]) begin
        a_done++;
        if (prev && !busy_s[i] && txd_s[i]) a_done_ok = 1'b1;
      end
      prev = busy_s[i];
    end
    nb = 10 + par;
    if (a_first < 0 || (a_first - 1 + nb * cpb) > txd_s.size()) begin
      a_periods_ok = 1'b0;
    end else begin
      base = a_first - 1;
      for (int j = 0; j < nb; j++)
        for (int s = 0; s < cpb; s++)
          if (txd_s[base + j * cpb + s] !== txd_s[base + j * cpb]) a_periods_ok = 1'b0;
      a_start = txd_s[base];
      for (int b = 0; b < 8; b++) a_byte[b] = txd_s[base + (1 + b) * cpb];
      if (par != 0) a_par = txd_s[base + 9 * cpb];
      a_stop = txd_s[base + (9 + par) * cpb];
    end
  endtask

  task automatic frame_checks(input string tag, input int cpb, input int par,
                              input logic [7:0] exp_byte, input logic exp_par,
                              input int exp_len, input int exp_first);
    analyze(cpb, par);
    check({tag, " latency"},   a_first, exp_first);
    check({tag, " busy_len"},  a_len, exp_len);
    check({tag, " frames"},    a_frames, 1);
    check({tag, " periods"},   int'(a_periods_ok), 1);
    check({tag, " start"},     int'(a_start), 0);
    check({tag, " byte"},      int'(a_byte), int'(exp_byte));
    if (par != 0) check({tag, " parity"}, int'(a_par), int'(exp_par));
    check({tag, " stop"},      int'(a_stop), 1);
    check({tag, " done_cnt"},  a_done, 1);
    check({tag, " done_pos"},  int'(a_done_ok), 1);
    $display("%s: byte=%02h busy=%0d first=%0d done=%0d", tag, a_byte, a_len, a_first, a_done);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [7:0] exp_byte;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{dut: 0, data: 8'h0B, exp_byte: 8'h0B, exp_par: 1'b1, exp_len: 40};
    vecs[1] = '{dut: 1, data: 8'h07, exp_byte: 8'h07, exp_par: 1'b1, exp_len: 44};
    vecs[2] = '{dut: 1, data: 8'h03, exp_byte: 8'h03, exp_par: 1'b0, exp_len: 44};
    vecs[3] = '{dut: 1, data: 8'h80, exp_byte: 8'h80, exp_par: 1'b1, exp_len: 44};
    vecs[4] = '{dut: 1, data: 8'hA5, exp_byte: 8'hA5, exp_par: 1'b0, exp_len: 44};
    vecs[5] = '{dut: 2, data: 8'hA5, exp_byte: 8'hA5, exp_par: 1'b0, exp_len: 20};
    vecs[6] = '{dut: 3, data: 8'hA5, exp_byte: 8'hA5, exp_par: 1'b0, exp_len: 1040};
    vecs[7] = '{dut: 0, data: 8'h00, exp_byte: 8'h00, exp_par: 1'b0, exp_len: 40};
    vecs[8] = '{dut: 0, data: 8'hFF, exp_byte: 8'hFF, exp_par: 1'b0, exp_len: 40};
    vecs[9] = '{dut: 2, data: 8'h3C, exp_byte: 8'h3C, exp_par: 1'b0, exp_len: 20};

    reset  = 1'b1;
    en_r   = '0;
    data_r = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_txd%0d", d),  int'(txd_w[d]), 1);
      check($sformatf("rst_busy%0d", d), int'(busy_w[d]), 0);
      check($sformatf("rst_done%0d", d), int'(done_w[d]), 0);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_txd0", int'(txd_w[0]), 1);
    check("idle_busy0", int'(busy_w[0]), 0);

    // Table-driven frames
    for (int v = 0; v < 10; v++) begin
      int d;
      d = vecs[v].dut;
      data_r[d] = vecs[v].data;
      en_r[d]   = 1'b1;
      capture(d, vecs[v].exp_len + 12, 1'b1);
      en_r[d] = 1'b0;
      frame_checks($sformatf("vec%0d", v), cpb_of(d), par_of(d),
                   vecs[v].exp_byte, vecs[v].exp_par, vecs[v].exp_len, 3);
      repeat (6) @(negedge clk);
    end

    // Dropped request: new edge mid-DATA with data changing to FF
    data_r[0] = 8'h0B;
    en_r[0]   = 1'b1;
    capture(0, 11, 1'b1);
    en_r[0]   = 1'b0;
    data_r[0] = 8'hFF;
    capture(0, 2, 1'b0);
    en_r[0] = 1'b1;
    capture(0, 50, 1'b0);
    frame_checks("dropped", 4, 0, 8'h0B, 1'b0, 40, 3);
    // Level still high: no further frame
    capture(0, 60, 1'b1);
    analyze(4, 0);
    check("held_no_frame", a_frames, 0);
    check("held_no_busy", a_len, 0);
    $display("held: frames=%0d busy=%0d", a_frames, a_len);
    en_r[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during DATA bit 3 (edge 20 after the request)
    data_r[0] = 8'h0B;
    en_r[0]   = 1'b1;
    capture(0, 15, 1'b1);
    en_r[0] = 1'b0;
    capture(0, 4, 1'b0);
    reset = 1'b1;
    capture(0, 1, 1'b0);
    reset = 1'b0;
    capture(0, 40, 1'b0);
    analyze(4, 0);
    check("rst_mid_busy_before", int'(busy_s[18]), 1);
    check("rst_mid_busy_after", int'(busy_s[19]), 0);
    check("rst_mid_txd_after", int'(txd_s[19]), 1);
    check("rst_mid_done", a_done, 0);
    check("rst_mid_frames", a_frames, 1);
    $display("reset mid-frame: busy_after=%0d txd_after=%0d done=%0d", busy_s[19], txd_s[19], a_done);
    data_r[0] = 8'h5C;
    en_r[0]   = 1'b1;
    capture(0, 52, 1'b1);
    en_r[0] = 1'b0;
    frame_checks("after_rst", 4, 0, 8'h5C, 1'b0, 40, 3);
    repeat (6) @(negedge clk);

    // Request level held high across reset release
    reset = 1'b1;
    repeat (2) @(negedge clk);
    data_r[0] = 8'h0B;
    en_r[0]   = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_rst_txd", int'(txd_w[0]), 1);
    check("hold_rst_busy", int'(busy_w[0]), 0);
    reset = 1'b0;
    capture(0, 70, 1'b1);
    frame_checks("thru_rst", 4, 0, 8'h0B, 1'b0, 40, 3);
    en_r[0] = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
